// File: rtl/dram_ctrl.sv
// dram_ctrl: initiator-side controller between a PIM compute client and the
// dram bank model. It runs one full-row read or write at a time and drives
// the dram command interface. Write rows go out as BURST_LEN beats. Read
// beats are assembled back into a row.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready        client request handshake (ready only in IDLE)
//   req_we, req_addr,          request: direction, row address, write row
//   req_wdata
//   resp_valid/resp_ready      response handshake (valid held until accepted)
//   resp_rdata, resp_err       assembled read row (0 for writes), error flag
//   addr, read_en, write_en    dram command outputs (registered)
//   wdata                      current write beat, muxed by the beat pointer
//   dram_ready, dram_complete, dram status inputs
//   valid, rdata               dram beat strobe and read beat

module dram_ctrl #(
    parameter int ADDRESS_LEN        = 8,
    parameter int BURST_ACCESS_WIDTH = 32,
    parameter int BURST_LEN          = 4,
    parameter int TIMEOUT_CYCLES     = 64
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    req_valid,
    output logic                                    req_ready,
    input  logic                                    req_we,
    input  logic [ADDRESS_LEN-1:0]                  req_addr,
    input  logic [BURST_LEN*BURST_ACCESS_WIDTH-1:0] req_wdata,
    output logic                                    resp_valid,
    input  logic                                    resp_ready,
    output logic [BURST_LEN*BURST_ACCESS_WIDTH-1:0] resp_rdata,
    output logic                                    resp_err,
    output logic [ADDRESS_LEN-1:0]                  addr,
    output logic                                    read_en,
    output logic                                    write_en,
    output logic [BURST_ACCESS_WIDTH-1:0]           wdata,
    input  logic                                    dram_ready,
    input  logic                                    dram_complete,
    input  logic                                    valid,
    input  logic [BURST_ACCESS_WIDTH-1:0]           rdata
);

    localparam int RW  = BURST_LEN * BURST_ACCESS_WIDTH;
    localparam int BAW = BURST_ACCESS_WIDTH;
    localparam int BW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int RBW = $clog2(BURST_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BW-1:0]  WBEAT_MAX  = BW'(BURST_LEN - 1);
    localparam logic [RBW-1:0] RBEAT_FULL = RBW'(BURST_LEN);
    localparam logic [TW-1:0]  TCNT_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ACCESS,
        S_RESP,
        S_GAP
    } state_t;

    state_t state_q, state_d;

    // Control registers (reset)
    logic                   req_ready_d, resp_valid_d, resp_err_d;
    logic                   read_en_d, write_en_d, we_q, we_d;
    logic [ADDRESS_LEN-1:0] addr_d;
    logic [RW-1:0]          resp_rdata_d;
    logic [BW-1:0]          wbeat_q, wbeat_d;
    logic [RBW-1:0]         rbeat_q, rbeat_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;

    // Data registers (not reset; always loaded before use)
    logic [ADDRESS_LEN-1:0] addr_q, addr_lat_d;
    logic [RW-1:0]          wrow_q, wrow_d;
    logic [RW-1:0]          rbuf_q, rbuf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            read_en    <= 1'b0;
            write_en   <= 1'b0;
            addr       <= '0;
            resp_rdata <= '0;
            wbeat_q    <= '0;
            rbeat_q    <= '0;
            tcnt_q     <= '0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            read_en    <= read_en_d;
            write_en   <= write_en_d;
            addr       <= addr_d;
            resp_rdata <= resp_rdata_d;
            wbeat_q    <= wbeat_d;
            rbeat_q    <= rbeat_d;
            tcnt_q     <= tcnt_d;
            we_q       <= we_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_lat_d;
        wrow_q <= wrow_d;
        rbuf_q <= rbuf_d;
    end

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready;
        resp_valid_d = resp_valid;
        resp_err_d   = resp_err;
        read_en_d    = read_en;
        write_en_d   = write_en;
        addr_d       = addr;
        resp_rdata_d = resp_rdata;
        wbeat_d      = wbeat_q;
        rbeat_d      = rbeat_q;
        tcnt_d       = tcnt_q;
        we_d         = we_q;
        addr_lat_d   = addr_q;
        wrow_d       = wrow_q;
        rbuf_d       = rbuf_q;

        unique case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready) begin
                    we_d        = req_we;
                    addr_lat_d  = req_addr;
                    wrow_d      = req_wdata;
                    wbeat_d     = '0;
                    rbeat_d     = '0;
                    resp_err_d  = 1'b0;
                    rbuf_d      = '0;
                    req_ready_d = 1'b0;
                    state_d     = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (dram_ready) begin
                    read_en_d  = !we_q;
                    write_en_d = we_q;
                    addr_d     = addr_q;
                    tcnt_d     = '0;
                    state_d    = S_ACCESS;
                end
            end

            S_ACCESS: begin
                tcnt_d = tcnt_q + 1'b1;
                if (we_q) begin
                    if (valid && (wbeat_q != WBEAT_MAX))
                        wbeat_d = wbeat_q + 1'b1;
                end else if (valid && (rbeat_q < RBEAT_FULL)) begin
                    for (int k = 0; k < BURST_LEN; k++) begin
                        if (rbeat_q == RBW'(k))
                            rbuf_d[k*BAW +: BAW] = rdata;
                    end
                    rbeat_d = rbeat_q + 1'b1;
                end

                // A beat sampled on the completing edge still counts, so the
                // short-read check and the returned row use the updated values.
                if (dram_complete) begin
                    read_en_d    = 1'b0;
                    write_en_d   = 1'b0;
                    resp_err_d   = !we_q && (rbeat_d != RBEAT_FULL);
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? '0 : rbuf_d;
                    state_d      = S_RESP;
                end else if (tcnt_q == TCNT_LAST) begin
                    read_en_d    = 1'b0;
                    write_en_d   = 1'b0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? '0 : rbuf_d;
                    state_d      = S_RESP;
                end
            end

            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_GAP;
                end
            end

            // One idle cycle so the dram model leaves DONE before a new issue.
            S_GAP: begin
                req_ready_d = 1'b1;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wdata = '0;
        for (int k = 0; k < BURST_LEN; k++) begin
            if (wbeat_q == BW'(k))
                wdata = wrow_q[k*BAW +: BAW];
        end
    end

endmodule
